spi_counter_slave: RTL and testbench

SPI mode-0 slave that terminates the link driven by the counter-streaming SPI master. It receives one frame per SS_n assertion, consisting of two bytes: the LSB byte, then the MSB byte. It reassembles and validates the 14-bit up-counter value and presents it to downstream logic such as the FND display driver. On MISO it echoes the last accepted value, so the master side can loop-check the link. All SPI inputs are asynchronous to `clk` and are oversampled.

---
 rtl/spi_counter_slave.sv | 178 +++++++++++++++++
 tb/tb_spi_counter_slave.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_counter_slave.sv
// rtl/spi_counter_slave.sv - SPI mode-0 slave receiving 2-byte counter frames with MISO echo
module spi_counter_slave #(
    parameter int SYNC_STAGES = 2,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic [13:0] count,
    output logic        count_valid,
    output logic        frame_err,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RX_LSB = 2'd1;
    localparam logic [1:0] RX_MSB = 2'd2;
    localparam logic [1:0] RX_OVF = 2'd3;
    localparam logic [2:0] FILL   = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [2:0]             fill_cnt;
    logic                   armed;
    logic                   frame_start;

    logic [1:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  sh, lsb_reg, msb_reg;
    logic        ovf;
    logic [13:0] frame_value;
    logic        range_ok, accept;
    logic [7:0]  new_byte;

    logic        tx_active;
    logic [7:0]  tx_sh;
    logic [4:0]  fall_cnt;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // The reset-loaded SS_n=1 must not pass for a real high level: a frame only
    // starts once genuine samples have filled the chain and SS_n was seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= 3'd0;
            armed    <= 1'b0;
        end else begin
            if (fill_cnt != FILL)
                fill_cnt <= fill_cnt + 3'd1;
            if (fill_cnt == FILL && ss_s)
                armed <= 1'b1;
        end
    end

    assign frame_start = ss_fall & armed & (state == IDLE);
    assign new_byte    = {sh[6:0], mosi_s};
    assign frame_value = {msb_reg[5:0], lsb_reg};
    assign range_ok    = !CHECK_RANGE || (frame_value <= 14'd9999);
    assign accept      = (state == RX_OVF) && !ovf && (msb_reg[7:6] == 2'b00) && range_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            sh            <= 8'd0;
            lsb_reg       <= 8'd0;
            msb_reg       <= 8'd0;
            ovf           <= 1'b0;
            count         <= 14'd0;
            count_valid   <= 1'b0;
            frame_err     <= 1'b0;
            rx_byte       <= 8'd0;
            rx_byte_valid <= 1'b0;
        end else begin
            count_valid   <= 1'b0;
            frame_err     <= 1'b0;
            rx_byte_valid <= 1'b0;
            if (ss_rise && state != IDLE) begin
                // A same-cycle SCLK rise is dropped; the frame is judged as it stands.
                state   <= IDLE;
                bit_cnt <= 3'd0;
                if (accept) begin
                    count       <= frame_value;
                    count_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= 3'd0;
                        ovf     <= 1'b0;
                        if (frame_start)
                            state <= RX_LSB;
                    end
                    RX_LSB, RX_MSB: begin
                        if (sclk_rise) begin
                            sh      <= new_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_byte       <= new_byte;
                                rx_byte_valid <= 1'b1;
                                if (state == RX_LSB) begin
                                    lsb_reg <= new_byte;
                                    state   <= RX_MSB;
                                end else begin
                                    msb_reg <= new_byte;
                                    state   <= RX_OVF;
                                end
                            end
                        end
                    end
                    default: begin
                        if (sclk_rise)
                            ovf <= 1'b1;
                    end
                endcase
            end
        end
    end

    // The echo is the accepted count itself: low byte first, then the padded high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_sh     <= 8'd0;
            fall_cnt  <= 5'd0;
        end else if (frame_start) begin
            tx_active <= 1'b1;
            tx_sh     <= count[7:0];
            fall_cnt  <= 5'd0;
        end else if (ss_rise) begin
            tx_active <= 1'b0;
            fall_cnt  <= 5'd0;
        end else if (tx_active && sclk_fall) begin
            if (fall_cnt != 5'd16)
                fall_cnt <= fall_cnt + 5'd1;
            if (fall_cnt == 5'd7)
                tx_sh <= {2'b00, count[13:8]};
            else if (fall_cnt >= 5'd15)
                tx_sh <= 8'd0;
            else
                tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end

    assign MISO = tx_active & tx_sh[7];

endmodule

// File: tb/tb_spi_counter_slave.sv
// tb/tb_spi_counter_slave.sv - scoreboard bench for spi_counter_slave at 2 and 3 sync stages
module tb_spi_counter_slave;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } evt_t;

    localparam logic [1:0] K_RX  = 2'd0;
    localparam logic [1:0] K_CNT = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;
    localparam int HALF = 4;
    localparam int GAP  = 8;

    logic clk = 1'b0;
    logic rst, SCLK, MOSI, SS_n;

    logic        miso2, cv2, fe2, rbv2;
    logic [13:0] cnt2;
    logic [7:0]  rb2;
    logic        miso3, cv3, fe3, rbv3;
    logic [13:0] cnt3;
    logic [7:0]  rb3;

    evt_t q2[$];
    evt_t q3[$];
    int total = 0;
    int bad   = 0;
    logic [15:0] cap2, cap3;

    always #5 clk = ~clk;

    spi_counter_slave #(.SYNC_STAGES(2), .CHECK_RANGE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(miso2),
        .count(cnt2), .count_valid(cv2), .frame_err(fe2), .rx_byte(rb2), .rx_byte_valid(rbv2)
    );

    spi_counter_slave #(.SYNC_STAGES(3), .CHECK_RANGE(1'b1)) dut3 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(miso3),
        .count(cnt3), .count_valid(cv3), .frame_err(fe3), .rx_byte(rb3), .rx_byte_valid(rbv3)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [15:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        q2.push_back(e);
        q3.push_back(e);
    endtask

    task automatic pop_check(input int inst, input logic [1:0] kind, input logic [15:0] act);
        evt_t e;
        logic empty;
        empty = (inst == 2) ? (q2.size() == 0) : (q3.size() == 0);
        total++;
        if (empty) begin
            bad++;
            $display("FAIL evt_unexpected inst=%0d actual kind=%0d data=%h required=none", inst, kind, act);
        end else begin
            if (inst == 2) e = q2.pop_front();
            else           e = q3.pop_front();
            if (e.kind !== kind || e.data !== act) begin
                bad++;
                $display("FAIL evt inst=%0d actual kind=%0d data=%h required kind=%0d data=%h",
                         inst, kind, act, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rbv2) pop_check(2, K_RX, {8'h00, rb2});
        if (cv2)  pop_check(2, K_CNT, {2'b00, cnt2});
        if (fe2)  pop_check(2, K_ERR, 16'h0000);
    end

    always @(negedge clk) begin
        if (rbv3) pop_check(3, K_RX, {8'h00, rb3});
        if (cv3)  pop_check(3, K_CNT, {2'b00, cnt3});
        if (fe3)  pop_check(3, K_ERR, 16'h0000);
    end

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits, input int rst_at);
        logic [15:0] word;
        word = {b0, b1};
        cap2 = 16'h0000;
        cap3 = 16'h0000;
        SS_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            MOSI = (i < 16) ? word[15-i] : 1'b1;
            tick(HALF);
            if (i < 16) begin
                cap2[15-i] = miso2;
                cap3[15-i] = miso3;
            end
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end
        tick(HALF);
        SS_n = 1'b1;
        tick(GAP);
    endtask

    task automatic good_frame(input logic [13:0] v);
        push(K_RX, {8'h00, v[7:0]});
        push(K_RX, {10'h000, v[13:8]});
        push(K_CNT, {2'b00, v});
        frame(v[7:0], {2'b00, v[13:8]}, 16, -1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count2"}, {2'b00, cnt2}, 16'h0000);
        chk({tag, "_count3"}, {2'b00, cnt3}, 16'h0000);
        chk({tag, "_rxbyte2"}, {8'h00, rb2}, 16'h0000);
        chk({tag, "_rxbyte3"}, {8'h00, rb3}, 16'h0000);
        chk({tag, "_miso"}, {14'h0000, miso2, miso3}, 16'h0000);
        chk({tag, "_pulses"}, {10'h000, cv2, fe2, rbv2, cv3, fe3, rbv3}, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        chk_reset_state("reset");

        good_frame(14'h0539);
        chk("miso_f1_2", cap2, 16'h0000);
        chk("miso_f1_3", cap3, 16'h0000);

        good_frame(14'h270F);
        chk("miso_f2_2", cap2, 16'h3905);
        chk("miso_f2_3", cap3, 16'h3905);

        push(K_RX, 16'h0010); push(K_RX, 16'h0027); push(K_ERR, 16'h0000);
        frame(8'h10, 8'h27, 16, -1);
        push(K_RX, 16'h0000); push(K_RX, 16'h0040); push(K_ERR, 16'h0000);
        frame(8'h00, 8'h40, 16, -1);
        chk("count_kept", {2'b00, cnt2}, 16'h270F);

        push(K_RX, 16'h000F); push(K_ERR, 16'h0000);
        frame(8'h0F, 8'h27, 11, -1);
        push(K_RX, 16'h000F); push(K_ERR, 16'h0000);
        frame(8'h0F, 8'h27, 8, -1);
        push(K_RX, 16'h000F); push(K_RX, 16'h0027); push(K_ERR, 16'h0000);
        frame(8'h0F, 8'h27, 17, -1);

        good_frame(14'h0001);
        chk("miso_f9_2", cap2, 16'h0F27);
        chk("miso_f9_3", cap3, 16'h0F27);

        push(K_RX, 16'h0022);
        frame(8'h22, 8'h11, 16, 13);
        chk_reset_state("midrst");

        good_frame(14'h1234);
        good_frame(14'd100);
        good_frame(14'd2000);
        good_frame(14'd9998);
        good_frame(14'h1FFF);

        tick(20);
        chk("q2_drained", 16'(q2.size()), 16'h0000);
        chk("q3_drained", 16'(q3.size()), 16'h0000);
        chk("final_count2", {2'b00, cnt2}, 16'h1FFF);
        chk("final_count3", {2'b00, cnt3}, 16'h1FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
